// File: rtl/framebuffer_fill.sv
// framebuffer_fill: Avalon-MM write master that clears a pixel buffer to one RGB565 colour
module framebuffer_fill #(
    parameter logic [15:0] H_RESOLUTION    = 16'd256,
    parameter logic [15:0] V_RESOLUTION    = 16'd192,
    parameter int          ROW_STRIDE_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] buffer_base,
    input  logic [15:0] fill_color,
    input  logic        irq_clear,
    output logic        busy,
    output logic        done,
    output logic        irq,
    output logic [31:0] m1_address,
    output logic [31:0] m1_writedata,
    output logic        m1_write,
    input  logic        m1_waitrequest
);
    localparam int HW = int'(H_RESOLUTION) / 2;
    localparam int VR = int'(V_RESOLUTION);
    localparam int XW = (HW > 1) ? $clog2(HW) : 1;
    localparam int YW = (VR > 1) ? $clog2(VR) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(HW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VR - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [31:0]    r_base;
    logic [15:0]    r_color;
    logic [XW-1:0]  r_xw;
    logic [YW-1:0]  r_y;
    logic           r_irq;
    logic           w_start;
    logic           w_accept;
    logic           w_x_end;
    logic           w_last;
    logic [31:0]    w_addr;

    assign w_start  = (r_state == S_IDLE) && start && !abort;
    assign w_accept = (r_state == S_WRITE) && !m1_waitrequest;
    assign w_x_end  = r_xw == X_LAST;
    assign w_last   = w_x_end && (r_y == Y_LAST);
    assign w_addr   = r_base + (32'(r_y) << ROW_STRIDE_LOG2) + (32'(r_xw) << 2);
    assign irq      = r_irq;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: a transfer is only left once the pending word has been accepted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_WRITE : S_IDLE;
            S_WRITE: w_next = (w_accept && (w_last || abort)) ? S_DONE : S_WRITE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: bus signals are zero outside WRITE so nothing stale is presented
    always_comb begin
        busy         = r_state == S_WRITE;
        m1_write     = r_state == S_WRITE;
        done         = r_state == S_DONE;
        m1_address   = (r_state == S_WRITE) ? w_addr : 32'd0;
        m1_writedata = (r_state == S_WRITE) ? {r_color, r_color} : 32'd0;
    end

    // Latch base/colour on an accepted start, then walk x-words and rows on each accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_base  <= '0;
            r_color <= '0;
            r_xw    <= '0;
            r_y     <= '0;
        end else if (w_start) begin
            r_base  <= buffer_base;
            r_color <= fill_color;
            r_xw    <= '0;
            r_y     <= '0;
        end else if (w_accept) begin
            r_xw <= w_x_end ? '0 : r_xw + 1'b1;
            r_y  <= w_x_end ? r_y + 1'b1 : r_y;
        end
    end

    // Sticky interrupt; setting in DONE takes priority over a simultaneous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 r_irq <= 1'b0;
        else if (r_state == S_DONE) r_irq <= 1'b1;
        else if (irq_clear)        r_irq <= 1'b0;
    end
endmodule

// File: tb/tb_framebuffer_fill.sv
// tb_framebuffer_fill: directed self-checking bench for a small and a default-size fill engine
module tb_framebuffer_fill;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_s;
    logic        start_f;
    logic        abort;
    logic [31:0] base;
    logic [15:0] color;
    logic        irq_clear;
    logic        wait_r;
    logic        s_busy, s_done, s_irq, s_write;
    logic [31:0] s_addr, s_data;
    logic        f_busy, f_done, f_irq, f_write;
    logic [31:0] f_addr, f_data;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_s = 0;
    int          n_f = 0;
    logic [31:0] last_f = 32'd0;
    logic [31:0] last_fd = 32'd0;
    logic [31:0] exp_a [4] = '{32'h0800_0000, 32'h0800_0004, 32'h0800_0400, 32'h0800_0404};

    framebuffer_fill #(.H_RESOLUTION(16'd4), .V_RESOLUTION(16'd2)) u_small (
        .clock(clk), .reset(reset), .start(start_s), .abort(abort),
        .buffer_base(base), .fill_color(color), .irq_clear(irq_clear),
        .busy(s_busy), .done(s_done), .irq(s_irq),
        .m1_address(s_addr), .m1_writedata(s_data), .m1_write(s_write),
        .m1_waitrequest(wait_r)
    );

    framebuffer_fill u_full (
        .clock(clk), .reset(reset), .start(start_f), .abort(abort),
        .buffer_base(base), .fill_color(color), .irq_clear(irq_clear),
        .busy(f_busy), .done(f_done), .irq(f_irq),
        .m1_address(f_addr), .m1_writedata(f_data), .m1_write(f_write),
        .m1_waitrequest(wait_r)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_write && !wait_r) n_s++;
        if (f_write && !wait_r) begin
            n_f++;
            last_f  = f_addr;
            last_fd = f_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] c);
        base    = b;
        color   = c;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_wr"}, 32'(s_write), 32'd1);
        check({tag, "_addr"}, s_addr, a);
        check({tag, "_data"}, s_data, d);
    endtask

    initial begin
        int n0;
        int cyc;
        reset = 1'b1; start_s = 1'b0; start_f = 1'b0; abort = 1'b0;
        base = 32'd0; color = 16'd0; irq_clear = 1'b0; wait_r = 1'b0;
        #12;
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_done", 32'(s_done), 32'd0);
        check("rst_irq", 32'(s_irq), 32'd0);
        check("rst_write", 32'(s_write | f_write), 32'd0);
        check("rst_addr", s_addr, 32'd0);
        check("rst_data", s_data, 32'd0);
        reset = 1'b0;
        tick();

        // zero-wait small frame
        n0 = n_s;
        do_start(32'h0800_0000, 16'hF800);
        check("t1_busy", 32'(s_busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            expect_word("t1", exp_a[k], 32'hF800_F800);
            tick();
        end
        check("t1_done", 32'(s_done), 32'd1);
        check("t1_busy_end", 32'(s_busy), 32'd0);
        check("t1_write_end", 32'(s_write), 32'd0);
        check("t1_irq_early", 32'(s_irq), 32'd0);
        check("t1_count", 32'(n_s - n0), 32'd4);
        tick();
        check("t1_irq", 32'(s_irq), 32'd1);
        check("t1_done_pulse", 32'(s_done), 32'd0);

        // waitrequest stall on word 2
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("t2_irq_clr", 32'(s_irq), 32'd0);
        n0 = n_s;
        do_start(32'h1000_0000, 16'h07E0);
        expect_word("t2_w0", 32'h1000_0000, 32'h07E0_07E0);
        tick();
        wait_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_word("t2_stall", 32'h1000_0004, 32'h07E0_07E0);
            tick();
        end
        wait_r = 1'b0;
        expect_word("t2_w1", 32'h1000_0004, 32'h07E0_07E0);
        tick();
        expect_word("t2_w2", 32'h1000_0400, 32'h07E0_07E0);
        tick();
        expect_word("t2_w3", 32'h1000_0404, 32'h07E0_07E0);
        tick();
        check("t2_done", 32'(s_done), 32'd1);
        check("t2_count", 32'(n_s - n0), 32'd4);
        tick();

        // abort while word 2 is stalled
        n0 = n_s;
        do_start(32'h3000_0000, 16'h1234);
        expect_word("t3_w0", 32'h3000_0000, 32'h1234_1234);
        tick();
        wait_r = 1'b1;
        abort  = 1'b1;
        expect_word("t3_hold", 32'h3000_0004, 32'h1234_1234);
        tick();
        expect_word("t3_hold2", 32'h3000_0004, 32'h1234_1234);
        tick();
        wait_r = 1'b0;
        expect_word("t3_w1", 32'h3000_0004, 32'h1234_1234);
        tick();
        abort = 1'b0;
        check("t3_done", 32'(s_done), 32'd1);
        check("t3_write", 32'(s_write), 32'd0);
        tick();
        check("t3_done_once", 32'(s_done), 32'd0);
        check("t3_idle", 32'(s_busy | s_write), 32'd0);
        check("t3_count", 32'(n_s - n0), 32'd2);

        // start with abort in IDLE does nothing
        n0 = n_s;
        base = 32'h0900_0000; start_s = 1'b1; abort = 1'b1;
        tick();
        start_s = 1'b0; abort = 1'b0;
        check("t4_busy", 32'(s_busy | s_write), 32'd0);
        check("t4_done", 32'(s_done), 32'd0);
        tick();
        check("t4_done2", 32'(s_done), 32'd0);
        check("t4_count", 32'(n_s - n0), 32'd0);

        // start during WRITE is ignored
        do_start(32'h4000_0000, 16'hAAAA);
        expect_word("t5_w0", 32'h4000_0000, 32'hAAAA_AAAA);
        base = 32'h5000_0000; color = 16'h5555; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        expect_word("t5_w1", 32'h4000_0004, 32'hAAAA_AAAA);
        tick();
        expect_word("t5_w2", 32'h4000_0400, 32'hAAAA_AAAA);
        tick();
        expect_word("t5_w3", 32'h4000_0404, 32'hAAAA_AAAA);
        tick();
        check("t5_done", 32'(s_done), 32'd1);
        tick();

        // irq clear racing DONE
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("t6_irq_pre", 32'(s_irq), 32'd0);
        do_start(32'h0000_0000, 16'hFFFF);
        repeat (4) tick();
        check("t6_done", 32'(s_done), 32'd1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("t6_irq_set_wins", 32'(s_irq), 32'd1);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        check("t6_irq_cleared", 32'(s_irq), 32'd0);

        // async reset mid-transfer with waitrequest high
        do_start(32'h6000_0000, 16'h0F0F);
        expect_word("t7_w0", 32'h6000_0000, 32'h0F0F_0F0F);
        tick();
        wait_r = 1'b1;
        tick();
        check("t7_stalled", 32'(s_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t7_busy", 32'(s_busy), 32'd0);
        check("t7_write", 32'(s_write), 32'd0);
        check("t7_addr", s_addr, 32'd0);
        check("t7_data", s_data, 32'd0);
        check("t7_done_irq", 32'({s_done, s_irq}), 32'd0);
        #2 reset = 1'b0;
        wait_r = 1'b0;
        tick();
        check("t7_idle", 32'(s_busy), 32'd0);
        do_start(32'h7000_0000, 16'h00FF);
        expect_word("t7_restart", 32'h7000_0000, 32'h00FF_00FF);
        repeat (4) tick();
        check("t7_done", 32'(s_done), 32'd1);
        tick();

        // full frame at default resolution
        base = 32'h2000_0000; color = 16'h001F; start_f = 1'b1;
        tick();
        start_f = 1'b0;
        n0 = n_f;
        check("t8_busy", 32'(f_busy), 32'd1);
        check("t8_first", f_addr, 32'h2000_0000);
        cyc = 0;
        while (!f_done && cyc < 30000) begin
            tick();
            cyc++;
        end
        check("t8_cycles", 32'(cyc), 32'd24576);
        check("t8_count", 32'(n_f - n0), 32'd24576);
        check("t8_last_addr", last_f, 32'h2002_FDFC);
        check("t8_last_data", last_fd, 32'h001F_001F);
        check("t8_busy_end", 32'(f_busy), 32'd0);
        tick();
        check("t8_irq", 32'(f_irq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/framebuffer_fill.md
# framebuffer_fill

Avalon-MM write-master engine that fills a pixel buffer with one RGB565 colour, giving the GPU a hardware back-buffer clear ahead of voxel rasterisation. It sits behind the GPU's register slave: the slave supplies the buffer base, colour and a start pulse. This block drives the GPU's m1 master port, walking every pixel word of an H_RESOLUTION × V_RESOLUTION frame. Completion is reported by a one-cycle done pulse and a sticky irq.

## Interface

Parameters:
- H_RESOLUTION, 16'd256, pixels per row; must be even and ≥ 2.
- V_RESOLUTION, 16'd192, rows per frame; must be ≥ 1.
- ROW_STRIDE_LOG2, 10, log2 of the byte stride between rows (1024-byte rows).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset.
- start  in  1  one-cycle request to begin a fill; honoured only in IDLE.
- abort  in  1  request to stop a fill early; level-sampled each cycle.
- buffer_base  in  32  byte address of pixel (0,0); latched on an accepted start.
- fill_color  in  16  RGB565 colour; latched on an accepted start.
- irq_clear  in  1  clears irq.
- busy  out  1  high from the cycle after an accepted start until the fill ends.
- done  out  1  one-cycle pulse when a fill ends (complete or aborted).
- irq  out  1  sticky; set with done, cleared by irq_clear.
- m1_address  out  32  Avalon-MM byte address.
- m1_writedata  out  32  {colour, colour}: two pixels per word.
- m1_write  out  1  Avalon-MM write request.
- m1_waitrequest  in  1  Avalon-MM stall.

## Operation

States:
- **IDLE:** m1_write = 0, busy = 0.
  - start=1 and abort=0 → latch buffer_base and fill_color; clear counters; go to WRITE.
  - start=1 and abort=1 in the same cycle → abort wins; stay IDLE; no done pulse.
- **WRITE:**
  - m1_write = 1; m1_address = base + (y << ROW_STRIDE_LOG2) + (xw << 2); m1_writedata = {color, color}.
  - A word is accepted on a cycle with m1_write=1 and m1_waitrequest=0.
  - On accept: xw increments. At xw = H_RESOLUTION/2 − 1 it wraps to 0 and y increments.
  - Accept of the last word (xw = H/2−1, y = V−1), or accept while abort=1 → go to DONE.
  - While m1_waitrequest=1, address, data and write are held stable. Abort is deferred until the pending word is accepted; a transfer is never withdrawn.
- **DONE:** one cycle. done = 1, busy = 0, m1_write = 0; irq set. Then go to IDLE.

Rules:
- Counters: xw is ceil(log2(H/2)) bits; y is ceil(log2(V)) bits.
- Address arithmetic is 32-bit unsigned, wrapping modulo 2^32.
- start while busy: ignored; the latched base and colour are unaffected.
- Changes to buffer_base or fill_color mid-fill have no effect.
- irq: set by DONE, cleared by irq_clear. irq_clear in the same cycle as DONE: set wins, irq = 1.
- abort in IDLE or DONE: no effect.

Reset:
- Reset at any time, including mid-transfer with waitrequest high, forces IDLE immediately.
- All outputs reset to 0: busy, done, irq, m1_write, m1_address, m1_writedata.
- Counters and latched base/colour reset to 0.

## Timing

- start accepted in cycle N → busy=1 and m1_write=1 with the first address in cycle N+1.
- With m1_waitrequest held 0, one word is written per cycle. A full frame takes (H/2)·V cycles: 24576 at the defaults.
- Each waitrequest-high cycle adds exactly one cycle.
- The cycle after the final accept is DONE: done=1, busy=0, m1_write=0. irq=1 from the following cycle.
- Earliest restart: start in the cycle after DONE (IDLE).
- Abort asserted in the cycle of an accept → that word is the last one written; DONE follows on the next cycle.

## Test plan

- **Zero-wait small frame** (H=4, V=2, base=0x0800_0000, color=0xF800, waitrequest=0):
  - Exactly 4 writes, on consecutive cycles, to 0x0800_0000, 0x0800_0004, 0x0800_0400, 0x0800_0404, all with data 0xF800F800.
  - done pulses in the cycle after the 4th write; irq rises next.
- **Waitrequest stall:**
  - Hold waitrequest=1 for 3 cycles on the 2nd word → address and data are stable for those 3 cycles.
  - The sequence completes in 4+3 write cycles with no word skipped or repeated.
- **Abort mid-stall:**
  - Assert abort while waitrequest=1 on word 2 → the write is held until waitrequest drops.
  - Word 2 is accepted, no word 3 is issued, and done pulses once.
- **Start hazards:**
  - start together with abort in IDLE → no writes, no done.
  - start during WRITE with a new base/colour → ignored; addresses and data stay on the original values.
- **irq:**
  - irq_clear in the DONE cycle → irq=1 afterwards.
  - irq_clear one cycle later → irq=0.
- **Reset and full frame:**
  - Async reset mid-frame with waitrequest=1 → all outputs 0 at once; a new start then begins again at base.
  - Default parameters → 24576 writes; the last address is base + 191·1024 + 508.
